fmap_pingpong_ram: RTL and testbench

Double-buffered feature-map RAM for the NPU datapath. Two banks of ROWS*COLS words: a producer (image loader or previous layer) fills one bank while a consumer (convolution engine) reads the other through NUM_RD parallel registered read ports. Bank ownership swaps via done-pulse handshakes, so load and compute overlap without the consumer seeing a partially written map.

---
 rtl/fmap_pingpong_ram.sv | 120 ++++++++++++
 tb/tb_fmap_pingpong_ram.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fmap_pingpong_ram.sv
// Double-buffered feature-map RAM.
//
// Two banks of ROWS*COLS words. A producer fills the write bank while a consumer reads the other
// bank through NUM_RD parallel registered read ports. Banks change hands through done pulses.
// wr_done marks the write bank full and passes it to the reader. rd_done marks the read bank
// empty and passes it back to the writer. The reader therefore never sees a partially written
// map.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   wr_en/addr/data       write strobe, address (row*COLS+col) and data
//   wr_done               pulse: hand the current write bank to the reader
//   wr_ready, wr_bank     write bank is empty and owned by the writer; current write bank index
//   rd_en, rd_addr        read strobe shared by all ports; packed per-port addresses
//   rd_done               pulse: release the current read bank to the writer
//   rd_avail, rd_bank     read bank is full and owned by the reader; current read bank index
//   rd_data, rd_valid     packed per-port registered data; 1-cycle pulse per accepted read
module fmap_pingpong_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 28,
  parameter int unsigned COLS   = 28,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_done,
  output logic                       wr_ready,
  output logic                       wr_bank,
  input  logic                       rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic                       rd_done,
  output logic                       rd_avail,
  output logic                       rd_bank,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic                       rd_valid
);

  localparam int unsigned DEPTH = ROWS * COLS;
  // DEPTH is one bit wider than an address so that the range compare cannot wrap.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  // Storage is not reset, so it can map onto plain block RAM.
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_word;
  logic                    rd_valid_q;

  logic wr_acc, wr_done_acc, rd_acc, rd_done_acc;

  assign wr_ready = ~full_q[wr_bank_q];
  assign rd_avail = full_q[rd_bank_q];
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  assign wr_acc      = wr_en & wr_ready & ({1'b0, wr_addr} < DEPTH_X);
  assign wr_done_acc = wr_done & wr_ready;
  assign rd_acc      = rd_en & rd_avail;
  assign rd_done_acc = rd_done & rd_avail;

  // The bank indices are sampled before this edge, so a write in the same cycle as wr_done
  // lands in the old bank.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (wr_bank_q) mem1[wr_addr] <= wr_data;
      else           mem0[wr_addr] <= wr_data;
    end
  end

  // Per-port read mux. An out-of-range address returns zero on that port only.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              in_range;
    assign a        = rd_addr[p*ADDR_W +: ADDR_W];
    assign in_range = ({1'b0, a} < DEPTH_X);
    assign rd_word[p*DATA_W +: DATA_W] = !in_range ? '0 : (rd_bank_q ? mem1[a] : mem0[a]);
  end

  // Next-state logic for bank ownership. wr_done and rd_done can only address different banks,
  // so both updates apply in the same cycle.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_done_acc) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_done_acc) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= rd_word;
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// Directed testbench for fmap_pingpong_ram using the default 28x28, 2-port configuration.
module tb_fmap_pingpong_ram;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_done;
  logic                     wr_ready;
  logic                     wr_bank;
  logic                     rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic                     rd_done;
  logic                     rd_avail;
  logic                     rd_bank;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     rd_valid;

  int checks   = 0;
  int failures = 0;

  fmap_pingpong_ram #(
    .DATA_W(DATA_W), .ROWS(28), .COLS(28), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_avail(rd_avail), .rd_bank(rd_bank), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic wrdy, input logic wb,
                             input logic ravl, input logic rb);
    check({tag, ".wr_ready"}, {31'd0, wr_ready}, {31'd0, wrdy});
    check({tag, ".wr_bank"},  {31'd0, wr_bank},  {31'd0, wb});
    check({tag, ".rd_avail"}, {31'd0, rd_avail}, {31'd0, ravl});
    check({tag, ".rd_bank"},  {31'd0, rd_bank},  {31'd0, rb});
  endtask

  // Single-cycle read strobe, then sample the registered result.
  task automatic do_read(input int a0, input int a1);
    rd_en   = 1'b1;
    rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    tick();
    rd_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    tick(); tick();

    // Reset values
    check_state("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset.rd_data", {16'd0, rd_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Fill bank 0 with data = addr[7:0], then hand it over
    wr_en = 1'b1;
    for (int a = 0; a < 784; a++) begin
      wr_addr = ADDR_W'(a);
      wr_data = DATA_W'(a);
      tick();
    end
    wr_en   = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check_state("handover0", 1'b1, 1'b1, 1'b1, 1'b0);

    // Two-port read, latency 1, rd_valid single pulse, data held afterwards
    do_read(5, 783);
    check("rd1.data", {16'd0, rd_data}, 32'h0000_0F05);
    check("rd1.valid", {31'd0, rd_valid}, 32'd1);
    tick();
    check("rd1.valid_drop", {31'd0, rd_valid}, 32'd0);
    check("rd1.hold", {16'd0, rd_data}, 32'h0000_0F05);

    // Fill bank 1 with 0xAA while bank 0 is still owned by the reader
    wr_en = 1'b1;
    wr_data = 8'hAA;
    for (int a = 0; a < 784; a++) begin
      wr_addr = ADDR_W'(a);
      tick();
    end
    wr_en   = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check_state("bank1_full", 1'b0, 1'b0, 1'b1, 1'b0);

    // Writer is blocked: write to bank 0 and a second wr_done are both ignored
    wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = 8'h77; wr_done = 1'b1;
    tick();
    wr_en = 1'b0; wr_done = 1'b0;
    check_state("blocked", 1'b0, 1'b0, 1'b1, 1'b0);
    do_read(5, 6);
    check("blocked.rd", {16'd0, rd_data}, 32'h0000_0605);

    // Release bank 0: reader moves to bank 1, writer gets bank 0 back
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check_state("release0", 1'b1, 1'b0, 1'b1, 1'b1);
    do_read(10, 5);
    check("bank1.rd", {16'd0, rd_data}, 32'h0000_AAAA);

    // Out-of-range read zeroes only that port
    do_read(10, 800);
    check("oor.rd", {16'd0, rd_data}, 32'h0000_00AA);
    check("oor.valid", {31'd0, rd_valid}, 32'd1);

    // Out-of-range write is dropped; valid writes go into bank 0
    wr_en = 1'b1; wr_addr = ADDR_W'(900); wr_data = 8'h11;
    tick();
    wr_addr = ADDR_W'(10); wr_data = 8'h3C;
    tick();
    wr_addr = ADDR_W'(20); wr_data = 8'h55;
    tick();
    check_state("oor.wr", 1'b1, 1'b0, 1'b1, 1'b1);

    // Same cycle: write + wr_done + rd_en + rd_done
    wr_addr = ADDR_W'(30); wr_data = 8'h66; wr_done = 1'b1;
    rd_en = 1'b1; rd_addr = {ADDR_W'(20), ADDR_W'(10)}; rd_done = 1'b1;
    tick();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    check("simul.rd_old", {16'd0, rd_data}, 32'h0000_AAAA);
    check("simul.valid", {31'd0, rd_valid}, 32'd1);
    check_state("simul", 1'b1, 1'b1, 1'b1, 1'b0);
    do_read(10, 30);
    check("simul.new_bank", {16'd0, rd_data}, 32'h0000_663C);
    do_read(20, 5);
    check("simul.bank0_old", {16'd0, rd_data}, 32'h0000_0555);

    // Reset asserted right after an accepted read: outputs clear without waiting for a clock
    do_read(783, 10);
    check("prerst.valid", {31'd0, rd_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_state("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst.valid", {31'd0, rd_valid}, 32'd0);
    check("midrst.data", {16'd0, rd_data}, 32'd0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
